// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt sequencer for a pipelined core. Detects a self-jump halt, drains the pipe, then parks in HALTED.
// Optional pipe_en cycle counter is built only when RUN_CTRL_CYCLE_CNT_EN is defined.
module run_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  halt_req,
    input  logic                  id_is_jump,
    input  logic [ADDR_WIDTH-1:0] id_jump_addr,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  pipe_en,
    output logic                  halted,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH-1:0] halt_pc,
    output logic [31:0]           cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam int unsigned      CNT_W      = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam state_t           HALT_DEST  = (DRAIN_CYCLES == 0) ? S_HALTED : S_DRAIN;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        drain_q, drain_d;
    logic [ADDR_WIDTH-1:0]   pc_prev;
    logic                    halt_hit;
    logic                    halt_any;
    logic                    latch_pc;
    logic                    pipe_en_d;
    logic                    halted_d;

    // A halt instruction is a jump to itself: the ID-stage jump targets the
    // address one behind IF. Kept at ADDR_WIDTH so PC 0 wraps to all ones.
    assign pc_prev  = if_pc - ADDR_WIDTH'(1);
    assign halt_hit = id_is_jump && (id_jump_addr == pc_prev);
    assign halt_any = halt_hit || halt_req;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        drain_d  = drain_q;
        latch_pc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                if (halt_any) begin
                    state_d  = HALT_DEST;
                    drain_d  = DRAIN_LOAD;
                    latch_pc = halt_hit;
                end else if (state_q == S_STEP) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_q <= CNT_W'(1)) begin
                    state_d = S_HALTED;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
                drain_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        pipe_en_d = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
        halted_d  = (state_d == S_HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            pipe_en <= 1'b0;
            halted  <= 1'b0;
            halt_pc <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            pipe_en <= pipe_en_d;
            halted  <= halted_d;
            if (latch_pc) begin
                halt_pc <= id_jump_addr;
            end
        end
    end

    assign state = state_q;

`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    // Counts cycles in which the pipe advanced; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else if (pipe_en && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and randomized checks of run_ctrl against a behavioural model.
// Two instances share stimulus: default parameters, and an 8-bit / zero-drain variant.
module tb_run_ctrl;

`ifdef RUN_CTRL_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        id_is_jump = 1'b0;
    logic [31:0] id_jump_addr = '0;
    logic [31:0] if_pc = '0;

    logic        pipe_en, halted;
    logic [2:0]  state;
    logic [31:0] halt_pc, cycle_cnt;

    logic        pipe_en0, halted0;
    logic [2:0]  state0;
    logic [7:0]  halt_pc0;
    logic [31:0] cycle_cnt0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    run_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
        .id_is_jump(id_is_jump), .id_jump_addr(id_jump_addr), .if_pc(if_pc),
        .pipe_en(pipe_en), .halted(halted), .state(state), .halt_pc(halt_pc),
        .cycle_cnt(cycle_cnt)
    );

    run_ctrl #(.ADDR_WIDTH(8), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
        .id_is_jump(id_is_jump), .id_jump_addr(id_jump_addr[7:0]), .if_pc(if_pc[7:0]),
        .pipe_en(pipe_en0), .halted(halted0), .state(state0), .halt_pc(halt_pc0),
        .cycle_cnt(cycle_cnt0)
    );

    // Reference model: mode numbers are the documented state codes; 'left'
    // is the number of drain cycles still to be spent.
    typedef struct {
        int          mode;
        int          left;
        logic [31:0] pc;
        logic [31:0] cnt;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_next(model_t m, int dc, int aw, logic r, logic s,
                                          logic stp, logic hr, logic ij,
                                          logic [31:0] ja, logic [31:0] pc);
        logic [31:0] mask;
        logic        hit;
        model_t      n;
        n = m;
        if (r) begin
            n.mode = 0; n.left = 0; n.pc = '0; n.cnt = '0;
            return n;
        end
        mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        hit  = ij && ((ja & mask) == ((pc - 32'd1) & mask));
        if (CNT_EN && m.mode >= 1 && m.mode <= 3 && m.cnt != 32'hFFFF_FFFF)
            n.cnt = m.cnt + 32'd1;
        if (m.mode == 0) begin
            n.mode = s ? 1 : (stp ? 2 : 0);
        end else if (m.mode == 1 || m.mode == 2) begin
            if (hit || hr) begin
                if (hit) n.pc = ja & mask;
                if (dc == 0) n.mode = 4;
                else begin n.mode = 3; n.left = dc; end
            end else if (m.mode == 2) begin
                n.mode = 0;
            end
        end else if (m.mode == 3) begin
            n.left = m.left - 1;
            if (n.left == 0) n.mode = 4;
        end
        return n;
    endfunction

    function automatic logic [68:0] pack_exp(model_t m);
        logic [2:0] s;
        s = m.mode[2:0];
        return {s, (m.mode >= 1 && m.mode <= 3), (m.mode == 4), m.pc, m.cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_a = model_next(m_a, 3, 32, rst, start, step, halt_req, id_is_jump, id_jump_addr, if_pc);
        m_b = model_next(m_b, 0, 8, rst, start, step, halt_req, id_is_jump, id_jump_addr, if_pc);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; step = 0; halt_req = 0; id_is_jump = 0; id_jump_addr = '0; if_pc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; start = 1; halt_req = 1;
        tick(); tick();
        rst = 0; start = 0; halt_req = 0;
        n_checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
        n_checks++; if (pipe_en !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags got pe=%b h=%b want 0 0", pipe_en, halted); else n_pass++;
        n_checks++; if (halt_pc !== 32'd0 || cycle_cnt !== 32'd0) $display("FAIL reset_regs got pc=%h cnt=%0d want 0 0", halt_pc, cycle_cnt); else n_pass++;
        n_checks++; if (state0 !== 3'd0) $display("FAIL reset_state0 got %0d want 0", state0); else n_pass++;
    endtask

    task automatic test_run_halt_hit();
        do_reset();
        start = 1; tick(); start = 0;
        n_checks++; if (state !== 3'd1 || pipe_en !== 1'b1) $display("FAIL run_entry got st=%0d pe=%b want 1 1", state, pipe_en); else n_pass++;
        id_is_jump = 1; id_jump_addr = 32'h10; if_pc = 32'h11;
        tick();
        clear_inputs();
        n_checks++; if (state !== 3'd3 || halt_pc !== 32'h10) $display("FAIL hit_drain got st=%0d pc=%h want 3 10", state, halt_pc); else n_pass++;
        n_checks++; if (state0 !== 3'd4 || halted0 !== 1'b1 || halt_pc0 !== 8'h10) $display("FAIL hit_nodrain got st=%0d h=%b pc=%h want 4 1 10", state0, halted0, halt_pc0); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (state !== 3'd3 || pipe_en !== 1'b1) $display("FAIL drain_hold%0d got st=%0d pe=%b want 3 1", i, state, pipe_en); else n_pass++;
            n_checks++; if (state0 !== 3'd4) $display("FAIL nodrain_hold%0d got st=%0d want 4", i, state0); else n_pass++;
        end
        tick();
        n_checks++; if (state !== 3'd4 || halted !== 1'b1 || pipe_en !== 1'b0) $display("FAIL halted_entry got st=%0d h=%b pe=%b want 4 1 0", state, halted, pipe_en); else n_pass++;
        n_checks++; if ({state, pipe_en, halted, halt_pc, cycle_cnt} !== pack_exp(m_a)) $display("FAIL hit_model got %h want %h", {state, pipe_en, halted, halt_pc, cycle_cnt}, pack_exp(m_a)); else n_pass++;
    endtask

    task automatic test_step();
        do_reset();
        step = 1; tick(); step = 0;
        n_checks++; if (state !== 3'd2 || pipe_en !== 1'b1) $display("FAIL step_entry got st=%0d pe=%b want 2 1", state, pipe_en); else n_pass++;
        tick();
        n_checks++; if (state !== 3'd0 || pipe_en !== 1'b0) $display("FAIL step_return got st=%0d pe=%b want 0 0", state, pipe_en); else n_pass++;
        step = 1; start = 1; tick(); clear_inputs();
        n_checks++; if (state !== 3'd1 || state0 !== 3'd1) $display("FAIL start_wins got st=%0d st0=%0d want 1 1", state, state0); else n_pass++;
        do_reset();
        step = 1; tick(); step = 0; halt_req = 1; tick(); halt_req = 0;
        n_checks++; if (state !== 3'd3 || state0 !== 3'd4 || halt_pc !== 32'd0) $display("FAIL step_halt got st=%0d st0=%0d pc=%h want 3 4 0", state, state0, halt_pc); else n_pass++;
    endtask

    task automatic test_halt_req();
        do_reset();
        start = 1; tick(); start = 0;
        halt_req = 1; id_jump_addr = 32'h55; if_pc = 32'h99; tick(); clear_inputs();
        n_checks++; if (state !== 3'd3 || halt_pc !== 32'd0) $display("FAIL req_drain got st=%0d pc=%h want 3 0", state, halt_pc); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (state !== 3'd4 || halted !== 1'b1 || halt_pc !== 32'd0) $display("FAIL req_halted got st=%0d h=%b pc=%h want 4 1 0", state, halted, halt_pc); else n_pass++;
        do_reset();
        start = 1; tick(); start = 0;
        id_is_jump = 1; if_pc = 32'd0; id_jump_addr = 32'hFFFF_FFFF; tick(); clear_inputs();
        n_checks++; if (state !== 3'd3 || halt_pc !== 32'hFFFF_FFFF) $display("FAIL wrap_hit got st=%0d pc=%h want 3 ffffffff", state, halt_pc); else n_pass++;
        n_checks++; if (state0 !== 3'd4 || halt_pc0 !== 8'hFF) $display("FAIL wrap_hit0 got st=%0d pc=%h want 4 ff", state0, halt_pc0); else n_pass++;
        do_reset();
        start = 1; tick(); start = 0;
        id_is_jump = 1; if_pc = 32'h21; id_jump_addr = 32'h20; halt_req = 1; tick(); clear_inputs();
        n_checks++; if (state !== 3'd3 || halt_pc !== 32'h20) $display("FAIL hit_and_req got st=%0d pc=%h want 3 20", state, halt_pc); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        start = 1; tick(); start = 0;
        halt_req = 1; tick(); halt_req = 0;
        tick();
        rst = 1; start = 1; tick(); rst = 0;
        start = 0;
        n_checks++; if (state !== 3'd0 || halted !== 1'b0 || pipe_en !== 1'b0 || cycle_cnt !== 32'd0) $display("FAIL mid_drain_rst got st=%0d h=%b pe=%b cnt=%0d want 0 0 0 0", state, halted, pipe_en, cycle_cnt); else n_pass++;
        start = 1; tick(); start = 0;
        n_checks++; if (state !== 3'd1 || pipe_en !== 1'b1) $display("FAIL rerun got st=%0d pe=%b want 1 1", state, pipe_en); else n_pass++;
    endtask

    task automatic test_cycle_count();
        logic [31:0] want_a, want_b;
        want_a = CNT_EN ? 32'd14 : 32'd0;
        want_b = CNT_EN ? 32'd11 : 32'd0;
        do_reset();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 10; i++) begin
            if_pc = $urandom; id_jump_addr = if_pc + 32'd7; id_is_jump = $urandom_range(0, 1);
            tick();
        end
        id_is_jump = 1; if_pc = 32'h400; id_jump_addr = 32'h3FF; tick(); clear_inputs();
        tick(); tick(); tick();
        n_checks++; if (state !== 3'd4 || cycle_cnt !== want_a) $display("FAIL cnt_halted got st=%0d cnt=%0d want 4 %0d", state, cycle_cnt, want_a); else n_pass++;
        n_checks++; if (state0 !== 3'd4 || cycle_cnt0 !== want_b) $display("FAIL cnt_halted0 got st=%0d cnt=%0d want 4 %0d", state0, cycle_cnt0, want_b); else n_pass++;
        // HALTED must ignore every request until reset.
        for (int i = 0; i < 6; i++) begin
            start = $urandom_range(0, 1); step = $urandom_range(0, 1); halt_req = $urandom_range(0, 1);
            id_is_jump = 1; if_pc = $urandom; id_jump_addr = if_pc - 32'd1;
            tick();
            n_checks++; if (state !== 3'd4 || halted !== 1'b1 || pipe_en !== 1'b0 || cycle_cnt !== want_a || halt_pc !== 32'h3FF) $display("FAIL sticky%0d got st=%0d h=%b pe=%b cnt=%0d pc=%h want 4 1 0 %0d 3ff", i, state, halted, pipe_en, cycle_cnt, halt_pc, want_a); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [68:0] obs;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            start      = ($urandom_range(0, 7) == 0);
            step       = ($urandom_range(0, 3) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            if_pc      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            id_is_jump = ($urandom_range(0, 2) == 0);
            id_jump_addr = ($urandom_range(0, 3) == 0) ? if_pc - 32'd1 : $urandom;
            tick();
            obs = {state, pipe_en, halted, halt_pc, cycle_cnt};
            n_checks++; if (obs !== pack_exp(m_a)) $display("FAIL rand_a cycle %0d got %h want %h", i, obs, pack_exp(m_a)); else n_pass++;
            obs = {state0, pipe_en0, halted0, 24'd0, halt_pc0, cycle_cnt0};
            n_checks++; if (obs !== pack_exp(m_b)) $display("FAIL rand_b cycle %0d got %h want %h", i, obs, pack_exp(m_b)); else n_pass++;
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        m_a = '{0, 0, 32'd0, 32'd0};
        m_b = '{0, 0, 32'd0, 32'd0};
        test_reset();
        test_run_halt_hit();
        test_step();
        test_halt_req();
        test_reset_mid_drain();
        test_cycle_count();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of PC and jump-address inputs and of halt_pc.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: pipeline-enabled cycles after halt detection before HALTED.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level; request continuous run.
REQ-006 SHALL have port step  input  1  level; request one pipeline-enabled cycle.
REQ-007 SHALL have port halt_req  input  1  external abort request.
REQ-008 SHALL have port id_is_jump  input  1  ID stage holds a jump.
REQ-009 SHALL have port id_jump_addr  input  ADDR_WIDTH  jump target from ID.
REQ-010 SHALL have port if_pc  input  ADDR_WIDTH  current IF program counter.
REQ-011 SHALL have port pipe_en  output  1  global pipeline advance enable.
REQ-012 SHALL have port halted  output  1  processor stopped after drain.
REQ-013 SHALL have port state  output  3  FSM encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-014 SHALL have port halt_pc  output  ADDR_WIDTH  address of the detected halt (self-jump) instruction.
REQ-015 SHALL have port cycle_cnt  output  32  count of pipe_en-high cycles.

Function
REQ-016 SHALL define halt_hit = id_is_jump AND (id_jump_addr == if_pc - 1), subtraction modulo 2^ADDR_WIDTH (if_pc=0 compares with all ones).
REQ-017 SHALL register all outputs; pipe_en = 1 exactly in states RUN, STEP, DRAIN; halted = 1 exactly in HALTED.
REQ-018 SHALL transition IDLE->RUN on start; IDLE->STEP on step without start (start wins if both high); halt_req and halt_hit ignored in IDLE.
REQ-019 SHALL transition STEP->IDLE after exactly one cycle unless halt_hit or halt_req is sampled in STEP, in which case STEP->DRAIN.
REQ-020 SHALL transition RUN->DRAIN on halt_hit or halt_req; RUN otherwise holds, start/step ignored.
REQ-021 SHALL latch halt_pc <= id_jump_addr on the cycle halt_hit causes entry to DRAIN; halt_req alone leaves halt_pc unchanged; simultaneous halt_hit and halt_req latches.
REQ-022 SHALL load drain counter with DRAIN_CYCLES on DRAIN entry, stay in DRAIN exactly DRAIN_CYCLES cycles, then enter HALTED; DRAIN_CYCLES=0 SHALL go directly to HALTED, skipping DRAIN.
REQ-023 SHALL ignore halt_hit, halt_req, start, step during DRAIN and HALTED; HALTED is sticky until rst.
REQ-024 SHALL treat undefined state encodings (5-7) as IDLE on the next cycle.

Reset
REQ-025 SHALL on rst=1 at posedge force state=IDLE, pipe_en=0, halted=0, halt_pc=0, cycle_cnt=0, drain counter=0, overriding all other inputs including mid-DRAIN.
REQ-026 SHALL resume normal transitions on the first posedge with rst=0.

Configuration
REQ-027 SHALL, with macro RUN_CTRL_CYCLE_CNT_EN defined, increment cycle_cnt by 1 every cycle pipe_en=1, saturating at 32'hFFFFFFFF, holding otherwise.
REQ-028 SHALL, without RUN_CTRL_CYCLE_CNT_EN, drive cycle_cnt constant 0 and instantiate no counter register; all other behaviour identical.

Verification
REQ-029 SHALL cover: rst 1 cycle, start=1 -> state=1, pipe_en=1 next posedge; id_is_jump=1, id_jump_addr=0x10, if_pc=0x11 -> state=3, halt_pc=0x10, then exactly 3 cycles later state=4, halted=1, pipe_en=0.
REQ-030 SHALL cover: IDLE, step=1 one cycle -> pipe_en high exactly 1 cycle, state returns to 0; start=1 with step=1 -> state=1.
REQ-031 SHALL cover: RUN, halt_req=1 -> DRAIN, halt_pc stays 0, HALTED after 3 cycles; if_pc=0, id_jump_addr=all ones, id_is_jump=1 -> halt detected.
REQ-032 SHALL cover: rst asserted second cycle of DRAIN -> state=0, halted=0, cycle_cnt=0 next posedge; start afterwards re-enters RUN.
REQ-033 SHALL cover: with RUN_CTRL_CYCLE_CNT_EN, start, 10 RUN cycles, halt_hit, DRAIN_CYCLES=3 -> cycle_cnt=14 in HALTED (10 RUN + hit cycle + 3 DRAIN); without macro cycle_cnt=0 throughout.
REQ-034 SHALL cover: DRAIN_CYCLES=0, RUN, halt_hit -> state=4 next posedge, state 3 never observed.
